// File: rtl/ethernet_header_pkg.sv
// Shared Ethernet II header types for the RX header parser and its helpers.
// Header byte count, broadcast address, RX FSM states and a MAC byte-order helper.
package ethernet_header_pkg;

    localparam int          ETH_HDR_BYTES = 14;
    localparam logic [47:0] ETH_BCAST_MAC = 48'hffff_ffff_ffff;

    // Index 0 of every field is the first byte seen on the wire.
    typedef struct packed {
        logic [5:0][7:0] dst;
        logic [5:0][7:0] src;
        logic [1:0][7:0] ethertype;
    } ethernet_header;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        PAYLOAD,
        DROP
    } rx_state_e;

    // Network-order MAC ([47:40] first on the wire) to wire-indexed byte array.
    function automatic logic [5:0][7:0] mac_to_wire(input logic [47:0] mac);
        logic [5:0][7:0] b;
        for (int i = 0; i < 6; i++) begin
            b[i] = mac[8*(5-i) +: 8];
        end
        return b;
    endfunction

endpackage

// File: rtl/eth_header_parser_endian_pack.sv
// Packs a wire-indexed byte array (index 0 first on the wire) into a
// network-order integer whose most significant byte is the first wire byte.
module eth_header_parser_endian_pack #(
    parameter int N = 2
) (
    input  logic [N-1:0][7:0] wire_bytes,
    output logic [8*N-1:0]    word
);

    for (genvar i = 0; i < N; i++) begin : g_byte
        assign word[8*(N-1-i) +: 8] = wire_bytes[i];
    end

endmodule

// File: rtl/eth_header_parser.sv
// RX Ethernet II header parser: captures the 14-byte header, filters on the
// destination MAC and forwards the payload one cycle later.
module eth_header_parser
    import ethernet_header_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC        = 48'he86a64e7e829,
    parameter bit          PROMISCUOUS      = 1'b0,
    parameter bit          ACCEPT_BROADCAST = 1'b1,
    parameter int          CNT_W            = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output ethernet_header   hdr,
    output logic [47:0]      dst_mac,
    output logic [47:0]      src_mac,
    output logic [15:0]      ethertype,
    output logic             hdr_valid,
    output logic [7:0]       m_data,
    output logic             m_valid,
    output logic             m_last,
    output logic             err_short,
    output logic             rx_drop,
    output logic [CNT_W-1:0] cnt_ok,
    output logic [CNT_W-1:0] cnt_drop
);

    localparam logic [3:0] FILTER_IDX   = 4'd5;
    localparam logic [3:0] LAST_HDR_IDX = 4'(ETH_HDR_BYTES - 1);

    rx_state_e                     state;
    logic [3:0]                    byte_cnt;
    logic [ETH_HDR_BYTES-1:0][7:0] hdr_bytes;
    logic [5:0][7:0]               dst_wire;
    logic                          dst_accept;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // The byte arriving now completes the destination address at the filter edge.
    assign dst_wire   = {s_data, hdr_bytes[4:0]};
    assign dst_accept = PROMISCUOUS
                     || (dst_wire == mac_to_wire(LOCAL_MAC))
                     || (ACCEPT_BROADCAST && (dst_wire == mac_to_wire(ETH_BCAST_MAC)));

    // NOTE: the header staging buffer has no reset; every byte is written before it is read.
    always_ff @(posedge clk) begin
        if (s_valid && (state == IDLE || state == HEADER)) begin
            hdr_bytes[byte_cnt] <= s_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            byte_cnt  <= '0;
            hdr       <= '0;
            hdr_valid <= 1'b0;
            m_data    <= '0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            err_short <= 1'b0;
            rx_drop   <= 1'b0;
            cnt_ok    <= '0;
            cnt_drop  <= '0;
        end else begin
            // NOTE: pulses default low here; a later non-blocking write in this block wins.
            hdr_valid <= 1'b0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            err_short <= 1'b0;
            rx_drop   <= 1'b0;
            if (s_valid) begin
                case (state)
                    IDLE, HEADER: begin
                        if (byte_cnt == FILTER_IDX && !dst_accept) begin
                            rx_drop  <= 1'b1;
                            cnt_drop <= sat_inc(cnt_drop);
                            byte_cnt <= '0;
                            state    <= s_last ? IDLE : DROP;
                        end else if (byte_cnt == LAST_HDR_IDX) begin
                            hdr_valid <= 1'b1;
                            hdr       <= '{dst:       hdr_bytes[5:0],
                                           src:       hdr_bytes[11:6],
                                           ethertype: {s_data, hdr_bytes[12]}};
                            cnt_ok    <= sat_inc(cnt_ok);
                            byte_cnt  <= '0;
                            state     <= s_last ? IDLE : PAYLOAD;
                        end else if (s_last) begin
                            err_short <= 1'b1;
                            cnt_drop  <= sat_inc(cnt_drop);
                            byte_cnt  <= '0;
                            state     <= IDLE;
                        end else begin
                            byte_cnt <= byte_cnt + 4'd1;
                            state    <= HEADER;
                        end
                    end
                    PAYLOAD: begin
                        m_valid <= 1'b1;
                        m_data  <= s_data;
                        m_last  <= s_last;
                        if (s_last) state <= IDLE;
                    end
                    DROP: begin
                        if (s_last) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    eth_header_parser_endian_pack #(.N(6)) u_dst_pack (.wire_bytes(hdr.dst),       .word(dst_mac));
    eth_header_parser_endian_pack #(.N(6)) u_src_pack (.wire_bytes(hdr.src),       .word(src_mac));
    eth_header_parser_endian_pack #(.N(2)) u_typ_pack (.wire_bytes(hdr.ethertype), .word(ethertype));

endmodule

// File: tb/tb_eth_header_parser.sv
// Bench for eth_header_parser: two instances (broadcast accepted / rejected with
// 2-bit counters) share one byte stream; a frame-level model feeds a per-instance event scoreboard.
module tb_eth_header_parser;
    import ethernet_header_pkg::*;

    localparam logic [47:0] LOCAL = 48'he86a64e7e829;
    localparam logic [47:0] BCAST = 48'hffff_ffff_ffff;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] s_data = 8'h00;
    logic       s_valid = 1'b0;
    logic       s_last = 1'b0;

    always #5 clk = ~clk;

    ethernet_header hdr_w [2];
    logic [47:0]    dst_w [2];
    logic [47:0]    src_w [2];
    logic [15:0]    type_w[2];
    logic           hv_w  [2];
    logic [7:0]     md_w  [2];
    logic           mv_w  [2];
    logic           ml_w  [2];
    logic           es_w  [2];
    logic           rd_w  [2];
    logic [15:0]    cok0, cdr0;
    logic [1:0]     cok1, cdr1;

    eth_header_parser u_dut0 (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .hdr(hdr_w[0]), .dst_mac(dst_w[0]), .src_mac(src_w[0]), .ethertype(type_w[0]),
        .hdr_valid(hv_w[0]), .m_data(md_w[0]), .m_valid(mv_w[0]), .m_last(ml_w[0]),
        .err_short(es_w[0]), .rx_drop(rd_w[0]), .cnt_ok(cok0), .cnt_drop(cdr0)
    );

    eth_header_parser #(.ACCEPT_BROADCAST(1'b0), .CNT_W(2)) u_dut1 (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .hdr(hdr_w[1]), .dst_mac(dst_w[1]), .src_mac(src_w[1]), .ethertype(type_w[1]),
        .hdr_valid(hv_w[1]), .m_data(md_w[1]), .m_valid(mv_w[1]), .m_last(ml_w[1]),
        .err_short(es_w[1]), .rx_drop(rd_w[1]), .cnt_ok(cok1), .cnt_drop(cdr1)
    );

    typedef enum logic [1:0] {EV_HDR, EV_BEAT, EV_DROP, EV_SHORT} ev_kind_e;
    typedef struct {
        ev_kind_e       kind;
        logic [47:0]    dst;
        logic [47:0]    src;
        logic [15:0]    etype;
        ethernet_header h;
        logic [7:0]     data;
        logic           last;
    } ev_t;

    ev_t        q0[$];
    ev_t        q1[$];
    logic [7:0] frame[$];

    int checks = 0;
    int errors = 0;

    // Reference state per instance
    int             exp_ok  [2];
    int             exp_drop[2];
    logic [47:0]    exp_dst [2];
    logic [47:0]    exp_src [2];
    logic [15:0]    exp_et  [2];
    ethernet_header exp_hdr [2];
    localparam int  CMAX0 = 65535;
    localparam int  CMAX1 = 3;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_ev(input int d, input ev_t e);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic pop_ev(input int d, output ev_t e, output bit empty);
        empty = 1'b0;
        if (d == 0) begin
            if (q0.size() == 0) empty = 1'b1;
            else e = q0.pop_front();
        end else begin
            if (q1.size() == 0) empty = 1'b1;
            else e = q1.pop_front();
        end
    endtask

    function automatic int sat(input int v, input int d);
        int m;
        m = (d == 0) ? CMAX0 : CMAX1;
        return (v < m) ? v + 1 : v;
    endfunction

    // Frame-level model: outcome follows from length and destination address alone.
    task automatic model_frame();
        int             n;
        logic [47:0]    dst, src;
        logic [15:0]    et;
        ethernet_header h;
        bit             accept;
        ev_t            e;
        n = frame.size();
        dst = '0; src = '0; et = '0; h = '0;
        for (int i = 0; i < 6 && i < n; i++) begin
            dst = {dst[39:0], frame[i]};
            h.dst[i] = frame[i];
        end
        for (int i = 6; i < 12 && i < n; i++) begin
            src = {src[39:0], frame[i]};
            h.src[i-6] = frame[i];
        end
        for (int i = 12; i < 14 && i < n; i++) begin
            et = {et[7:0], frame[i]};
            h.ethertype[i-12] = frame[i];
        end
        for (int d = 0; d < 2; d++) begin
            accept = (dst == LOCAL) || ((d == 0) && (dst == BCAST));
            e.dst = dst; e.src = src; e.etype = et; e.h = h; e.data = '0; e.last = 1'b0;
            if (n >= 6 && !accept) begin
                e.kind = EV_DROP;
                push_ev(d, e);
                exp_drop[d] = sat(exp_drop[d], d);
            end else if (n < 14) begin
                e.kind = EV_SHORT;
                push_ev(d, e);
                exp_drop[d] = sat(exp_drop[d], d);
            end else begin
                e.kind = EV_HDR;
                push_ev(d, e);
                exp_ok[d]  = sat(exp_ok[d], d);
                exp_dst[d] = dst; exp_src[d] = src; exp_et[d] = et; exp_hdr[d] = h;
                for (int i = 14; i < n; i++) begin
                    e.kind = EV_BEAT;
                    e.data = frame[i];
                    e.last = (i == n - 1);
                    push_ev(d, e);
                end
            end
        end
    endtask

    task automatic build_frame(input logic [47:0] dst, input logic [47:0] src,
                               input logic [15:0] et, input int plen);
        frame.delete();
        for (int i = 5; i >= 0; i--) frame.push_back(dst[8*i +: 8]);
        for (int i = 5; i >= 0; i--) frame.push_back(src[8*i +: 8]);
        frame.push_back(et[15:8]);
        frame.push_back(et[7:0]);
        for (int i = 0; i < plen; i++) frame.push_back(8'($urandom));
    endtask

    task automatic idle_cycle();
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = 8'($urandom);
        @(posedge clk); #1;
    endtask

    task automatic send_bytes(input int n, input int gap_pct);
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < 4 && int'($urandom_range(99)) < gap_pct; g++) idle_cycle();
            s_valid = 1'b1;
            s_data  = frame[i];
            s_last  = (i == frame.size() - 1);
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame(input int gap_pct);
        model_frame();
        send_bytes(frame.size(), gap_pct);
    endtask

    task automatic clear_model();
        q0.delete();
        q1.delete();
        for (int d = 0; d < 2; d++) begin
            exp_ok[d] = 0; exp_drop[d] = 0;
            exp_dst[d] = '0; exp_src[d] = '0; exp_et[d] = '0; exp_hdr[d] = '0;
        end
    endtask

    // Monitor: every output event is matched against the front of its instance's queue.
    int       n_act;
    ev_t      mon_e;
    bit       mon_empty;
    ev_kind_e act_kind;
    logic     prev_sv = 1'b0;

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            n_act = int'(hv_w[d]) + int'(mv_w[d]) + int'(es_w[d]) + int'(rd_w[d]);
            if (n_act != 0) begin
                if (n_act > 1) check("single_event", n_act, 1);
                act_kind = hv_w[d] ? EV_HDR : mv_w[d] ? EV_BEAT : rd_w[d] ? EV_DROP : EV_SHORT;
                pop_ev(d, mon_e, mon_empty);
                if (mon_empty) begin
                    check($sformatf("unexpected_event%0d", d), act_kind, 4);
                end else begin
                    check($sformatf("event_kind%0d", d), act_kind, mon_e.kind);
                    if (mon_e.kind == EV_HDR && act_kind == EV_HDR) begin
                        check($sformatf("dst_mac%0d", d), dst_w[d], mon_e.dst);
                        check($sformatf("src_mac%0d", d), src_w[d], mon_e.src);
                        check($sformatf("ethertype%0d", d), type_w[d], mon_e.etype);
                        check($sformatf("hdr_struct%0d", d), hdr_w[d], mon_e.h);
                    end
                    if (mon_e.kind == EV_BEAT && act_kind == EV_BEAT) begin
                        check($sformatf("m_data%0d", d), md_w[d], mon_e.data);
                        check($sformatf("m_last%0d", d), ml_w[d], mon_e.last);
                        check($sformatf("m_valid_follows%0d", d), prev_sv, 1'b1);
                    end
                end
            end
        end
        prev_sv = s_valid;
    end

    task automatic check_zero(input int d);
        check($sformatf("rst_hdr_valid%0d", d), hv_w[d], 1'b0);
        check($sformatf("rst_m_valid%0d", d), mv_w[d], 1'b0);
        check($sformatf("rst_m_data%0d", d), md_w[d], 8'h00);
        check($sformatf("rst_dst%0d", d), dst_w[d], 48'h0);
        check($sformatf("rst_hdr%0d", d), hdr_w[d], 112'h0);
        check($sformatf("rst_type%0d", d), type_w[d], 16'h0);
    endtask

    task automatic check_held();
        check("cnt_ok0", cok0, exp_ok[0]);
        check("cnt_drop0", cdr0, exp_drop[0]);
        check("cnt_ok1", cok1, exp_ok[1]);
        check("cnt_drop1", cdr1, exp_drop[1]);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("held_dst%0d", d), dst_w[d], exp_dst[d]);
            check($sformatf("held_src%0d", d), src_w[d], exp_src[d]);
            check($sformatf("held_type%0d", d), type_w[d], exp_et[d]);
            check($sformatf("held_hdr%0d", d), hdr_w[d], exp_hdr[d]);
        end
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
    endtask

    initial begin
        int len;
        int pick;
        logic [47:0] rdst;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        check_zero(0);
        check_zero(1);
        check("rst_cnt_ok0", cok0, 16'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Unicast to the station, 4 payload bytes
        build_frame(LOCAL, 48'he86a64e7e830, 16'h0800, 4);
        send_frame(0);
        repeat (3) idle_cycle();
        check("t1_ethertype", type_w[0], 16'h0800);
        check("t1_cnt_ok", cok0, 16'd1);
        check_held();

        // Broadcast: accepted by instance 0, filtered by instance 1
        build_frame(BCAST, 48'h001122334455, 16'h0806, 3);
        send_frame(0);
        repeat (3) idle_cycle();
        check("t2_cnt_drop1", cdr1, 2'd1);
        check_held();

        // Foreign unicast dropped, then a good frame back-to-back
        build_frame(48'h020000000001, 48'h0a0b0c0d0e0f, 16'h86dd, 5);
        send_frame(0);
        build_frame(LOCAL, {16'h0242, 32'($urandom)}, 16'($urandom), 5);
        send_frame(0);
        repeat (3) idle_cycle();
        check_held();

        // Short 10-byte frame, then an exact 14-byte frame
        build_frame(LOCAL, 48'h111111111111, 16'h0800, 0);
        repeat (4) void'(frame.pop_back());
        send_frame(0);
        idle_cycle();
        build_frame(LOCAL, 48'h222222222222, 16'h0801, 0);
        send_frame(0);
        repeat (3) idle_cycle();
        check_held();

        // Test 1 stimulus with ~50% gaps
        build_frame(LOCAL, 48'he86a64e7e830, 16'h0800, 4);
        send_frame(50);
        repeat (3) idle_cycle();
        check_held();

        // Async reset during payload byte 2
        build_frame(LOCAL, 48'h333333333333, 16'h0800, 6);
        model_frame();
        send_bytes(16, 0);
        rst = 1'b1;
        #1;
        check_zero(0);
        check_zero(1);
        check("rst_mid_cnt_ok0", cok0, 16'd0);
        check("rst_mid_cnt_drop1", cdr1, 2'd0);
        clear_model();
        @(posedge clk); #1;
        rst = 1'b0;
        build_frame(LOCAL, 48'he86a64e7e830, 16'h0800, 4);
        send_frame(0);
        repeat (3) idle_cycle();
        check_held();

        // Random frames: mixed addresses, lengths and gaps (also saturates instance 1 counters)
        for (int f = 0; f < 24; f++) begin
            pick = int'($urandom_range(2));
            rdst = (pick == 0) ? LOCAL : (pick == 1) ? BCAST : {8'h02, 40'($urandom)};
            build_frame(rdst, {16'h0200, 32'($urandom)}, 16'($urandom), int'($urandom_range(10)));
            len = int'($urandom_range(frame.size(), 1));
            while (frame.size() > len) void'(frame.pop_back());
            send_frame(30);
            if ($urandom_range(1) == 1) idle_cycle();
        end
        repeat (4) idle_cycle();
        check_held();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
